mem_dmem_ctrl: RTL and testbench
================================

Name: mem_dmem_ctrl

Overview:
MEM-stage load/store sequencer for the MIPS pipeline. It accepts one memory-op instruction from EX/MEM and drives a variable-latency data-memory port with a req/ack handshake. While the access is in flight it stalls the pipeline. It then produces the register write-back triple (wdata, waddr, we), with byte/half lane steering and extension. Non-memory instructions pass through to write-back with one registered cycle.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles without dmem_ack before bus error (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mem_valid_i  in  1  instruction valid from EX/MEM
mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 = none
mem_addr_i  in  32  effective address
mem_sdata_i  in  32  store data (low bits used for SB/SH)
mem_wdata_i  in  32  ALU result for non-memory write-back
mem_waddr_i  in  5  destination register
mem_we_i  in  1  register write enable
stall_o  out  1  hold upstream; combinational
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  word address {addr[31:2],2'b00}
dmem_sel_o  out  4  byte enables, little-endian
dmem_wdata_o  out  32  lane-replicated store data
dmem_ack_i  in  1  access complete; rdata valid same cycle
dmem_rdata_i  in  32  read word
wb_wdata_o  out  32  write-back data, registered
wb_waddr_o  out  5  write-back register, registered
wb_we_o  out  1  write-back enable, registered
exc_misalign_o  out  1  one-cycle pulse, misaligned access
exc_buserr_o  out  1  one-cycle pulse, ack timeout
exc_badaddr_o  out  32  faulting address, held until next exception

Behaviour:
- Reset (rst=1 at edge): state IDLE, timeout counter 0, all registered outputs 0. stall_o=0 and dmem_req_o=0 while rst=1. Reset in BUSY abandons the access; dmem_req_o drops from the edge.
- States: IDLE, BUSY, DONE. dmem_* outputs come from the captured registers; dmem_req_o=1 only in BUSY.
- IDLE, mem_valid_i=0: wb_we_o<=0, wb_wdata_o<=0, wb_waddr_o<=0.
- IDLE, valid and op = none: wb_* <= mem_wdata_i / mem_waddr_i / mem_we_i. Latency 1; stall_o=0.
- IDLE, valid memory op, misaligned (half with addr[0]=1; word with addr[1:0]!=0): no request. stall_o=0, wb_we_o<=0, exc_misalign_o<=1, exc_badaddr_o<=addr. Remain IDLE.
- IDLE, valid aligned memory op: stall_o=1 combinationally. Capture op, addr, sdata, waddr, we; go BUSY; counter<=0.
- Lane rules: SB/LB/LBU sel=4'b0001<<addr[1:0]; SH/LH/LHU sel=4'b0011<<{addr[1],1'b0}; word sel=4'b1111. SB wdata={4{b}}, SH wdata={2{h}}, SW wdata=sdata.
- BUSY: stall_o=1; counter increments each cycle without ack.
- BUSY, dmem_ack_i=1: go DONE.
  - Load: wb_wdata_o <= selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); wb_waddr_o <= captured waddr; wb_we_o <= captured we.
  - Store: wb_we_o<=0.
- BUSY, no ack and counter = TIMEOUT_CYCLES-1: exc_buserr_o<=1, exc_badaddr_o<=addr, wb_we_o<=0; go DONE.
- Ack and timeout in the same cycle: ack wins; no error.
- DONE: stall_o=0, so upstream retires the completed instruction this cycle. Inputs are ignored. wb_we_o<=0; go IDLE.
- Every write-back result is visible for exactly one cycle. Exception pulses last one cycle. dmem_ack_i outside BUSY is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles mid-BUSY -> dmem_req_o=0 and wb_we_o=0 after the edge; state IDLE.
- Pass-through: valid, op=0, wdata=0x12345678, waddr=5, we=1 -> next cycle wb_*=0x12345678/5/1; stall_o never 1.
- LB: addr=0x1003, dmem_rdata=0x80AABBCC, ack after 3 BUSY cycles -> sel=1000, stall high 4 cycles, wb_wdata_o=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH: addr=0x2002, sdata=0xDEADBEEF -> dmem_we_o=1, sel=1100, wdata=0xBEEFBEEF; on ack wb_we_o=0.
- LW: addr=0x3001 -> exc_misalign_o pulse, exc_badaddr_o=0x3001, dmem_req_o stays 0, stall_o=0.
- Timeout: TIMEOUT_CYCLES=4, no ack -> req held 4 cycles, exc_buserr_o pulse, then DONE, then IDLE. Ack on the 4th cycle -> no error.

Source files
------------

// File: rtl/mem_dmem_ctrl.sv
// mem_dmem_ctrl: MEM-stage load/store sequencer.
// Takes one memory-op instruction from EX/MEM and runs it over a req/ack
// data-memory port. The upstream pipeline is stalled while the access is
// in flight. The result is returned as a registered write-back triple,
// with byte/half lane steering and sign or zero extension.
// Non-memory instructions go straight to write-back after one register stage.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid_i/op/addr/...   instruction from EX/MEM
//   stall_o                   combinational upstream hold
//   dmem_*                    data-memory request port (req/ack)
//   wb_wdata/waddr/we_o       registered write-back triple
//   exc_misalign_o            one-cycle pulse, misaligned access
//   exc_buserr_o              one-cycle pulse, no ack before timeout
//   exc_badaddr_o             faulting address, held until next exception
//
// state | meaning
// IDLE  | accepting; pass-through, misalign check, or start of an access
// BUSY  | request on the bus, waiting for ack or timeout
// DONE  | access finished; upstream retires the instruction, inputs ignored
module mem_dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic        mem_we_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_sel_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] wb_wdata_o,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic        exc_misalign_o,
  output logic        exc_buserr_o,
  output logic [31:0] exc_badaddr_o
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      op_q;
  logic [31:0]     addr_q;
  logic [4:0]      waddr_q;
  logic            we_q;

  // Access size: 0 none, 1 byte, 2 half, 3 word.
  logic [1:0]  size_in;
  logic        store_in;
  logic        misalign_in;
  logic        load_q;
  logic [3:0]  sel_in;
  logic [31:0] sdata_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  always_comb begin
    size_in  = 2'd0;
    store_in = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU: size_in = 2'd1;
      OP_LH, OP_LHU: size_in = 2'd2;
      OP_LW:         size_in = 2'd3;
      OP_SB: begin size_in = 2'd1; store_in = 1'b1; end
      OP_SH: begin size_in = 2'd2; store_in = 1'b1; end
      OP_SW: begin size_in = 2'd3; store_in = 1'b1; end
      default: ;
    endcase
  end

  assign misalign_in = ((size_in == 2'd2) && mem_addr_i[0]) ||
                       ((size_in == 2'd3) && (mem_addr_i[1:0] != 2'b00));

  // Byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    sel_in   = 4'b1111;
    sdata_in = mem_sdata_i;
    case (size_in)
      2'd1: begin
        sel_in   = 4'b0001 << mem_addr_i[1:0];
        sdata_in = {4{mem_sdata_i[7:0]}};
      end
      2'd2: begin
        sel_in   = 4'b0011 << {mem_addr_i[1], 1'b0};
        sdata_in = {2{mem_sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign load_q = (op_q >= OP_LB) && (op_q <= OP_LW);

  // Lane extraction for the captured load.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = dmem_rdata_i[7:0];
      2'd1:    lane_b = dmem_rdata_i[15:8];
      2'd2:    lane_b = dmem_rdata_i[23:16];
      default: lane_b = dmem_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data = {24'd0, lane_b};
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data = {16'd0, lane_h};
      default: load_data = dmem_rdata_i;
    endcase
  end

  // Stall asserts in the IDLE cycle that launches an access so the
  // upstream holds the instruction until DONE.
  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  stall_o = mem_valid_i && (size_in != 2'd0) && !misalign_in;
        S_BUSY:  stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign dmem_req_o = (state == S_BUSY) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt_q          <= '0;
      op_q           <= 4'd0;
      addr_q         <= 32'd0;
      waddr_q        <= 5'd0;
      we_q           <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= 32'd0;
      dmem_sel_o     <= 4'd0;
      dmem_wdata_o   <= 32'd0;
      wb_wdata_o     <= 32'd0;
      wb_waddr_o     <= 5'd0;
      wb_we_o        <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_buserr_o   <= 1'b0;
      exc_badaddr_o  <= 32'd0;
    end else begin
      // Write-back results and exception flags are single-cycle.
      wb_wdata_o     <= 32'd0;
      wb_waddr_o     <= 5'd0;
      wb_we_o        <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_buserr_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_valid_i) begin
            if (size_in == 2'd0) begin
              wb_wdata_o <= mem_wdata_i;
              wb_waddr_o <= mem_waddr_i;
              wb_we_o    <= mem_we_i;
            end else if (misalign_in) begin
              exc_misalign_o <= 1'b1;
              exc_badaddr_o  <= mem_addr_i;
            end else begin
              op_q         <= mem_op_i;
              addr_q       <= mem_addr_i;
              waddr_q      <= mem_waddr_i;
              we_q         <= mem_we_i;
              dmem_we_o    <= store_in;
              dmem_addr_o  <= {mem_addr_i[31:2], 2'b00};
              dmem_sel_o   <= sel_in;
              dmem_wdata_o <= sdata_in;
              cnt_q        <= '0;
              state        <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (dmem_ack_i) begin
            if (load_q) begin
              wb_wdata_o <= load_data;
              wb_waddr_o <= waddr_q;
              wb_we_o    <= we_q;
            end
            state <= S_DONE;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            exc_buserr_o  <= 1'b1;
            exc_badaddr_o <= addr_q;
            state         <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dmem_ctrl.sv
module tb_mem_dmem_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_sdata_i, mem_wdata_i;
  logic [4:0]  mem_waddr_i;
  logic        mem_we_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_sel_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] wb_wdata_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_we_o, exc_misalign_o, exc_buserr_o;
  logic [31:0] exc_badaddr_o;

  mem_dmem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .mem_wdata_i(mem_wdata_i),
    .mem_waddr_i(mem_waddr_i), .mem_we_i(mem_we_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_sel_o(dmem_sel_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_wdata_o(wb_wdata_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o),
    .exc_misalign_o(exc_misalign_o), .exc_buserr_o(exc_buserr_o),
    .exc_badaddr_o(exc_badaddr_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [4:0] addr; } wb_t;
  typedef struct { logic misalign; logic [31:0] addr; } exc_t;
  typedef struct { logic [31:0] addr; logic [3:0] sel; logic we; logic [31:0] wdata; } req_t;

  wb_t  wb_q[$];
  exc_t exc_q[$];
  req_t req_q[$];

  int checks = 0;
  int errors = 0;
  int plan_delay = 0;
  logic [31:0] plan_rdata = 32'd0;
  logic [31:0] last_bad = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derives expected bus request, stall length, write-back
  // and exceptions from the op/address rules, then drives the instruction
  // and holds it until the controller releases the stall.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] wdata,
                       input logic [4:0] waddr, input logic we,
                       input int delay, input logic [31:0] rdata);
    int size, exp_stall, n, sh;
    bit store, sgn;
    logic [31:0] v, m;
    req_t r;
    wb_t w;
    exc_t e;
    size = 0; store = 0; sgn = 0;
    case (op)
      1: begin size = 1; sgn = 1; end
      2: size = 1;
      3: begin size = 2; sgn = 1; end
      4: size = 2;
      5: size = 4;
      6: begin size = 1; store = 1; end
      7: begin size = 2; store = 1; end
      8: begin size = 4; store = 1; end
      default: size = 0;
    endcase
    exp_stall = 0;
    if (size == 0) begin
      if (we) begin w.data = wdata; w.addr = waddr; wb_q.push_back(w); end
    end else if (addr % size != 0) begin
      e.misalign = 1; e.addr = addr; exc_q.push_back(e); last_bad = addr;
    end else begin
      r.addr = addr & 32'hFFFF_FFFC;
      r.we = store;
      sh = (addr % 4) * 8;
      if (size == 1) begin
        r.sel = 4'(1 << (addr % 4));
        r.wdata = (sdata & 32'hFF) * 32'h0101_0101;
        m = 32'hFF;
      end else if (size == 2) begin
        r.sel = 4'(3 << (addr % 4));
        r.wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
        m = 32'hFFFF;
      end else begin
        r.sel = 4'hF;
        r.wdata = sdata;
        m = 32'hFFFF_FFFF;
      end
      req_q.push_back(r);
      if (delay > T) begin
        exp_stall = T + 1;
        e.misalign = 0; e.addr = addr; exc_q.push_back(e); last_bad = addr;
      end else begin
        exp_stall = delay + 1;
        if (!store && we) begin
          v = (rdata >> sh) & m;
          if (sgn && size == 1 && v >= 128) v = v - 256;
          if (sgn && size == 2 && v >= 32768) v = v - 65536;
          w.data = v; w.addr = waddr; wb_q.push_back(w);
        end
      end
    end
    @(negedge clk);
    plan_delay = delay; plan_rdata = rdata;
    mem_valid_i = 1; mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
    mem_wdata_i = wdata; mem_waddr_i = waddr; mem_we_i = we;
    #1;
    n = 0;
    while (stall_o && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_len", 32'(n), 32'(exp_stall));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_valid_i = 0; mem_op_i = 4'($urandom_range(0, 15)); mem_addr_i = $urandom;
    mem_wdata_i = $urandom; mem_we_i = 1;
  endtask

  // Memory responder: checks the request on its first BUSY cycle and acks
  // on the planned cycle; pulses stray acks while no request is up.
  initial begin
    int bcnt;
    req_t r;
    bcnt = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
    forever begin
      @(negedge clk);
      if (dmem_req_o) begin
        bcnt++;
        if (bcnt == 1) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", dmem_addr_o, 32'hxxxx_xxxx);
          end else begin
            r = req_q.pop_front();
            chk("req_addr", dmem_addr_o, r.addr);
            chk("req_sel", 32'(dmem_sel_o), 32'(r.sel));
            chk("req_we", 32'(dmem_we_o), 32'(r.we));
            if (r.we) chk("req_wdata", dmem_wdata_o, r.wdata);
          end
        end
        dmem_ack_i = (bcnt == plan_delay);
        dmem_rdata_i = dmem_ack_i ? plan_rdata : $urandom;
      end else begin
        bcnt = 0;
        dmem_ack_i = ($urandom_range(0, 3) == 0);
        dmem_rdata_i = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin
    wb_t w;
    exc_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_we_o) begin
          if (wb_q.size() == 0) chk("unexpected_wb", wb_wdata_o, 32'hxxxx_xxxx);
          else begin
            w = wb_q.pop_front();
            chk("wb_wdata", wb_wdata_o, w.data);
            chk("wb_waddr", 32'(wb_waddr_o), 32'(w.addr));
          end
        end
        if (exc_misalign_o || exc_buserr_o) begin
          if (exc_q.size() == 0) chk("unexpected_exc", exc_badaddr_o, 32'hxxxx_xxxx);
          else begin
            e = exc_q.pop_front();
            chk("exc_kind", {30'd0, exc_misalign_o, exc_buserr_o}, {30'd0, e.misalign, !e.misalign});
            chk("exc_badaddr", exc_badaddr_o, e.addr);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic [31:0] a;
    rst = 1; mem_valid_i = 0; mem_op_i = 0; mem_addr_i = 0; mem_sdata_i = 0;
    mem_wdata_i = 0; mem_waddr_i = 0; mem_we_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(dmem_req_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_wb_we", 32'(wb_we_o), 0);
    chk("rst_badaddr", exc_badaddr_o, 0);
    rst = 0;

    // Directed cases.
    issue(4'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 1, 32'h0);
    issue(4'd1, 32'h0000_1003, 32'h0, 32'h0, 5'd7, 1'b1, 3, 32'h80AA_BBCC);
    issue(4'd2, 32'h0000_1003, 32'h0, 32'h0, 5'd8, 1'b1, 3, 32'h80AA_BBCC);
    issue(4'd7, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, 2, 32'h0);
    issue(4'd5, 32'h0000_3001, 32'h0, 32'h0, 5'd3, 1'b1, 1, 32'h0);
    issue(4'd5, 32'h0000_4000, 32'h0, 32'h0, 5'd4, 1'b1, T + 2, 32'h0);
    issue(4'd5, 32'h0000_5000, 32'h0, 32'h0, 5'd6, 1'b1, T, 32'hCAFE_F00D);
    issue(4'd3, 32'h0000_6002, 32'h0, 32'h0, 5'd10, 1'b1, 1, 32'h9234_0000);

    // Reset in the middle of an access abandons it.
    req_q.push_back('{addr: 32'h0000_7000, sel: 4'hF, we: 1'b0, wdata: 32'h0});
    @(negedge clk);
    plan_delay = 99;
    mem_valid_i = 1; mem_op_i = 4'd5; mem_addr_i = 32'h0000_7000; mem_we_i = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_busy_stall", 32'(stall_o), 0);
    chk("rst_busy_req", 32'(dmem_req_o), 0);
    repeat (2) @(negedge clk);
    chk("rst_after_req", 32'(dmem_req_o), 0);
    chk("rst_after_wb_we", 32'(wb_we_o), 0);
    rst = 0; mem_valid_i = 0;
    last_bad = 32'h0;
    @(negedge clk);
    chk("post_rst_req", 32'(dmem_req_o), 0);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) idle_cycle();
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? a[1:0] : (op == 4'd3 || op == 4'd4 || op == 4'd7) ? {a[1], 1'b0} : 2'b00;
      issue(op, a, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(1, T + 2), $urandom);
    end

    idle_cycle();
    repeat (6) @(negedge clk);
    chk("wb_queue_drained", 32'(wb_q.size()), 0);
    chk("exc_queue_drained", 32'(exc_q.size()), 0);
    chk("req_queue_drained", 32'(req_q.size()), 0);
    chk("badaddr_held", exc_badaddr_o, last_bad);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
